pong_physics: RTL and testbench
===============================

# pong_physics

Parametrised game-state engine for the Pong design. It advances ball, player-paddle and AI-paddle positions once per enabled game tick on `clk_div`, and resolves wall bounces, paddle hits, misses and scoring. It also runs a serve / point / game-over state machine. Its registered positions and scores feed the VGA renderer, which runs on the pixel clock and samples them during vertical blanking.

## Interface
Parameters:
- `SCREEN_W`, 640, playfield width, px
- `SCREEN_H`, 480, playfield height, px
- `POS_W`, 10, position width; must hold `SCREEN_W`
- `BALL_SIZE`, 10, ball side length, px
- `PADDLE_W`, 10, paddle width, px
- `PADDLE_H`, 60, paddle height, px
- `LEFT_X`, 20, AI paddle left edge x
- `RIGHT_X`, 610, player paddle left edge x
- `BALL_SPEED`, 2, ball px per tick per axis
- `PADDLE_SPEED`, 2, player paddle px per tick
- `AI_SPEED`, 1, AI paddle px per tick
- `SCORE_W`, 4, score counter width
- `WIN_SCORE`, 9, score that ends the game
- `POINT_HOLD`, 30, ticks spent in POINT

Ports:
- `clk_div` in 1: game clock
- `rst_n` in 1: reset, synchronous, active-low
- `tick_en` in 1: advance one tick when high; all state holds when low
- `btn_up` in 1: player paddle up
- `btn_down` in 1: player paddle down
- `serve` in 1: level, sampled on ticks
- `ball_x`, `ball_y` out `POS_W`: ball top-left corner
- `paddle_y` out `POS_W`: player (right) paddle top edge
- `op_paddle_y` out `POS_W`: AI (left) paddle top edge
- `score_l`, `score_r` out `SCORE_W`: left and right scores
- `state` out 2: SERVE=0, PLAY=1, POINT=2, OVER=3
- `hit` out 1: one-tick pulse on paddle bounce
- `point` out 1: one-tick pulse on score
- `game_over` out 1: high while state is OVER

## Operation
- **Reset values:**
  - ball at centre: `ball_x`=(SCREEN_W−BALL_SIZE)/2=315, `ball_y`=(SCREEN_H−BALL_SIZE)/2=235
  - both paddles at (SCREEN_H−PADDLE_H)/2=210
  - scores 0, state SERVE, `dir_x`=1 (right), `dir_y`=1 (down), `serve_dir`=1
  - `hit`=`point`=0, hold counter 0
- **Arithmetic:** all position maths is done in `POS_W+1` bits, so subtraction never wraps. Results are clamped before being stored.
- **Player paddle** (SERVE and PLAY only):
  - `btn_up` has priority over `btn_down`.
  - Moves by `PADDLE_SPEED`, clamped to [0, SCREEN_H−PADDLE_H].
- **AI paddle** (PLAY only):
  - Compares ball centre (`ball_y`+BALL_SIZE/2) with paddle centre (`op_paddle_y`+PADDLE_H/2).
  - Ball centre smaller: move up by `AI_SPEED`. Larger: move down by `AI_SPEED`. Equal: hold.
  - Same clamp range as the player paddle.
- **SERVE:**
  - Ball held at centre.
  - `serve`=1 on a tick: `dir_x`←`serve_dir`, `dir_y`←1, go to PLAY. The ball does not move on this tick.
- **PLAY, y axis:**
  - If `dir_y`=1 and `ball_y`+BALL_SPEED ≥ SCREEN_H−BALL_SIZE: `ball_y`←SCREEN_H−BALL_SIZE, `dir_y`←0.
  - If `dir_y`=0 and `ball_y` ≤ BALL_SPEED: `ball_y`←0, `dir_y`←1.
  - Otherwise step by BALL_SPEED.
- **PLAY, x axis** (rules in priority order; x and y resolve independently in the same tick):
  1. Right paddle hit: `dir_x`=1, `ball_x`+BALL_SIZE ≤ RIGHT_X, `ball_x`+BALL_SIZE+BALL_SPEED ≥ RIGHT_X, and vertical overlap (`ball_y`+BALL_SIZE > `paddle_y` and `ball_y` < `paddle_y`+PADDLE_H). Then `ball_x`←RIGHT_X−BALL_SIZE, `dir_x`←0, `hit`=1.
  2. Left paddle hit: mirror image against LEFT_X+PADDLE_W, checked against `op_paddle_y`. Then `ball_x`←LEFT_X+PADDLE_W, `dir_x`←1, `hit`=1.
  3. Right miss: `dir_x`=1 and `ball_x`+BALL_SPEED ≥ SCREEN_W−BALL_SIZE. `score_l`++, `serve_dir`←1, `point`=1, go to POINT.
  4. Left miss: `dir_x`=0 and `ball_x` ≤ BALL_SPEED. `score_r`++, `serve_dir`←0, `point`=1, go to POINT.
  5. Otherwise step by BALL_SPEED.
- **POINT:**
  - Ball recentred, both paddles frozen.
  - Counts POINT_HOLD ticks.
  - Then goes to OVER if either score equals WIN_SCORE, else to SERVE.
- **OVER:**
  - Everything frozen.
  - `serve`=1 clears both scores, sets `serve_dir`←1, and goes to SERVE.
- Scores never exceed WIN_SCORE.

## Timing
- All outputs are registered. Every update happens on a `clk_div` rising edge with `tick_en`=1, so inputs take effect one tick later.
- `hit` and `point` are high for exactly one tick and cleared on the next enabled tick. When `tick_en`=0 they hold their value.
- Reset wins over `tick_en` and takes effect on any edge, including mid-PLAY or mid-POINT. The state after reset is identical to the reset values above.
- The POINT dwell is exactly POINT_HOLD enabled ticks, counted from the tick after `point` asserts.

## Structure
- `pong_pkg` holds:
  - state enum and its encoding
  - derived constants: `BALL_CX0`, `BALL_CY0`, `PADDLE_Y0`, `PADDLE_Y_MAX`
- Sub-module `pong_paddle_ctrl`: clamped up/down mover with speed and limit parameters. Instantiated twice:
  - player paddle, driven by the buttons
  - AI paddle, driven by the centre compare

## Test plan
All scenarios use default parameters.
- **Reset:** hold `rst_n`=0 for one edge → ball (315,235), both paddles 210, scores 0, `state`=SERVE, `hit`=`point`=0.
- **Serve:** `serve`=1 for one tick → `state`=PLAY. Next tick → ball (317,237).
- **Top wall:** force `ball_y`=1 with `dir_y`=0 → `ball_y`=0, `dir_y`=1. Next tick → `ball_y`=2.
- **Right paddle hit:** `paddle_y`=210, ball (598,230) moving right → `ball_x`=600, `dir_x`=0, `hit`=1 for one tick.
- **Miss:** `paddle_y`=0, ball (628,400) moving right → `score_l`=1 and `point` pulse. State stays POINT for 30 ticks, then SERVE with ball at (315,235).
- **Win:** `score_l`=8, then a miss → `score_l`=9, OVER after the hold, `game_over`=1. `serve`=1 → scores 0, `state`=SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-state engine.
// Contents:
//   state_t      - top-level game state encoding (SERVE/PLAY/POINT/OVER)
//   BALL_CX0 ... - derived reset positions for the default 640x480 playfield
//   centre_of()  - centring helper used to derive reset positions from parameters
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Offset that centres an object of length `size` inside a span of `span`.
  function automatic int centre_of(input int span, input int size);
    return (span - size) / 2;
  endfunction

  // Values for the default geometry; the engine re-derives them from its own
  // parameters, so a resized playfield stays consistent.
  localparam int BALL_CX0     = centre_of(640, 10);
  localparam int BALL_CY0     = centre_of(480, 10);
  localparam int PADDLE_Y0    = centre_of(480, 60);
  localparam int PADDLE_Y_MAX = 480 - 60;

endpackage

// File: rtl/pong_paddle_ctrl.sv
// Clamped vertical mover for one paddle.
// Ports:
//   clk_div, rst_n - game clock, synchronous active-low reset
//   en             - move allowed this cycle (tick and state qualified upstream)
//   up, down       - move request; up has priority
//   pos            - registered paddle top edge, held within [0, Y_MAX]
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int SPEED  = 2,
  parameter int Y_MAX  = 420,
  parameter int Y_INIT = 210
) (
  input  logic             clk_div,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  output logic [POS_W-1:0] pos
);

  localparam int XW = POS_W + 1;
  localparam logic [POS_W:0] SPD = XW'(SPEED);
  localparam logic [POS_W:0] LIM = XW'(Y_MAX);
  localparam logic [POS_W-1:0] INIT = POS_W'(Y_INIT);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W:0]   pos_ext;

  // One extra bit keeps the down-step compare from wrapping before the clamp.
  always_comb begin
    pos_ext = {1'b0, pos_q};
    pos_d   = pos_q;
    if (en) begin
      if (up) begin
        pos_d = (pos_ext <= SPD) ? '0 : POS_W'(pos_ext - SPD);
      end else if (down) begin
        pos_d = (pos_ext + SPD >= LIM) ? POS_W'(LIM) : POS_W'(pos_ext + SPD);
      end
    end
  end

  always_ff @(posedge clk_div) begin
    if (!rst_n) pos_q <= INIT;
    else        pos_q <= pos_d;
  end

  assign pos = pos_q;

endmodule

// File: rtl/pong_physics.sv
// Pong game-state engine: ball, player paddle and AI paddle motion, wall and
// paddle bounces, misses, scoring and the serve/point/game-over sequence.
// Everything advances only on clk_div edges with tick_en high.
// Ports:
//   clk_div, rst_n          - game clock, synchronous active-low reset
//   tick_en                 - one game tick per enabled edge
//   btn_up, btn_down        - player (right) paddle control
//   serve                   - starts play in SERVE, restarts the game in OVER
//   ball_x, ball_y          - ball top-left corner
//   paddle_y, op_paddle_y   - player (right) / AI (left) paddle top edges
//   score_l, score_r        - scores, saturating at WIN_SCORE
//   state                   - game state (see table)
//   hit, point              - one-tick pulses on paddle bounce / score
//   game_over               - high while in OVER
//
// state    | meaning
// ---------+----------------------------------------------------------
// SERVE    | ball parked at centre, player paddle live, waits for serve
// PLAY     | ball, both paddles moving; bounces, hits and misses resolved
// POINT    | ball parked, paddles frozen for POINT_HOLD ticks
// OVER     | a side reached WIN_SCORE; frozen until serve restarts game
module pong_physics
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int POS_W        = 10,
  parameter int BALL_SIZE    = 10,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 60,
  parameter int LEFT_X       = 20,
  parameter int RIGHT_X      = 610,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 2,
  parameter int AI_SPEED     = 1,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int POINT_HOLD   = 30
) (
  input  logic               clk_div,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               serve,
  output logic [POS_W-1:0]   ball_x,
  output logic [POS_W-1:0]   ball_y,
  output logic [POS_W-1:0]   paddle_y,
  output logic [POS_W-1:0]   op_paddle_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state,
  output logic               hit,
  output logic               point,
  output logic               game_over
);

  localparam int XW         = POS_W + 1;
  localparam int PADDLE_MAX = SCREEN_H - PADDLE_H;
  localparam int PADDLE_INI = centre_of(SCREEN_H, PADDLE_H);
  localparam int HOLD_W     = $clog2(POINT_HOLD + 1);

  localparam logic [POS_W:0] BALL_X0    = XW'(centre_of(SCREEN_W, BALL_SIZE));
  localparam logic [POS_W:0] BALL_Y0    = XW'(centre_of(SCREEN_H, BALL_SIZE));
  localparam logic [POS_W:0] BALL_X_MAX = XW'(SCREEN_W - BALL_SIZE);
  localparam logic [POS_W:0] BALL_Y_MAX = XW'(SCREEN_H - BALL_SIZE);
  localparam logic [POS_W:0] BSZ        = XW'(BALL_SIZE);
  localparam logic [POS_W:0] BSZ_HALF   = XW'(BALL_SIZE / 2);
  localparam logic [POS_W:0] SPD        = XW'(BALL_SPEED);
  localparam logic [POS_W:0] PH         = XW'(PADDLE_H);
  localparam logic [POS_W:0] PH_HALF    = XW'(PADDLE_H / 2);
  localparam logic [POS_W:0] R_FACE     = XW'(RIGHT_X);
  localparam logic [POS_W:0] L_FACE     = XW'(LEFT_X + PADDLE_W);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(POINT_HOLD - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  state_t               state_q, state_d;
  logic [POS_W-1:0]     ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic                 dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic                 serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
  logic                 hit_q, hit_d, point_q, point_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [POS_W:0]       bx_ext, by_ext, py_ext, oy_ext;
  logic                 hit_r, hit_l, miss_r, miss_l;
  logic                 ply_en, ai_en, ai_up, ai_down;

  always_comb begin
    bx_ext = {1'b0, ball_x_q};
    by_ext = {1'b0, ball_y_q};
    py_ext = {1'b0, paddle_y};
    oy_ext = {1'b0, op_paddle_y};

    hit_r  = dir_x_q && (bx_ext + BSZ <= R_FACE) && (bx_ext + BSZ + SPD >= R_FACE)
             && (by_ext + BSZ > py_ext) && (by_ext < py_ext + PH);
    // Mirror of the right-hand test written without subtraction.
    hit_l  = !dir_x_q && (bx_ext >= L_FACE) && (bx_ext <= L_FACE + SPD)
             && (by_ext + BSZ > oy_ext) && (by_ext < oy_ext + PH);
    miss_r = dir_x_q && (bx_ext + SPD >= BALL_X_MAX);
    miss_l = !dir_x_q && (bx_ext <= SPD);

    ply_en  = tick_en && ((state_q == ST_SERVE) || (state_q == ST_PLAY));
    ai_en   = tick_en && (state_q == ST_PLAY);
    ai_up   = (by_ext + BSZ_HALF) < (oy_ext + PH_HALF);
    ai_down = (by_ext + BSZ_HALF) > (oy_ext + PH_HALF);
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    serve_dir_d = serve_dir_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    hit_d       = hit_q;
    point_d     = point_q;
    hold_d      = hold_q;

    if (tick_en) begin
      hit_d   = 1'b0;
      point_d = 1'b0;
      case (state_q)
        ST_SERVE: begin
          ball_x_d = POS_W'(BALL_X0);
          ball_y_d = POS_W'(BALL_Y0);
          if (serve) begin
            dir_x_d = serve_dir_q;
            dir_y_d = 1'b1;
            state_d = ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (dir_y_q && (by_ext + SPD >= BALL_Y_MAX)) begin
            ball_y_d = POS_W'(BALL_Y_MAX);
            dir_y_d  = 1'b0;
          end else if (!dir_y_q && (by_ext <= SPD)) begin
            ball_y_d = '0;
            dir_y_d  = 1'b1;
          end else begin
            ball_y_d = dir_y_q ? POS_W'(by_ext + SPD) : POS_W'(by_ext - SPD);
          end

          // On a miss the ball is left where it is; POINT recentres it.
          if (hit_r) begin
            ball_x_d = POS_W'(R_FACE - BSZ);
            dir_x_d  = 1'b0;
            hit_d    = 1'b1;
          end else if (hit_l) begin
            ball_x_d = POS_W'(L_FACE);
            dir_x_d  = 1'b1;
            hit_d    = 1'b1;
          end else if (miss_r) begin
            score_l_d   = (score_l_q >= WIN) ? WIN : score_l_q + SCORE_W'(1);
            serve_dir_d = 1'b1;
            point_d     = 1'b1;
            hold_d      = HOLD_LOAD;
            state_d     = ST_POINT;
          end else if (miss_l) begin
            score_r_d   = (score_r_q >= WIN) ? WIN : score_r_q + SCORE_W'(1);
            serve_dir_d = 1'b0;
            point_d     = 1'b1;
            hold_d      = HOLD_LOAD;
            state_d     = ST_POINT;
          end else begin
            ball_x_d = dir_x_q ? POS_W'(bx_ext + SPD) : POS_W'(bx_ext - SPD);
          end
        end

        ST_POINT: begin
          ball_x_d = POS_W'(BALL_X0);
          ball_y_d = POS_W'(BALL_Y0);
          // Loaded with POINT_HOLD-1 on the miss, so the exit tick is the
          // POINT_HOLD-th tick spent here.
          if (hold_q == '0) begin
            state_d = ((score_l_q == WIN) || (score_r_q == WIN)) ? ST_OVER : ST_SERVE;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end

        ST_OVER: begin
          if (serve) begin
            score_l_d   = '0;
            score_r_d   = '0;
            serve_dir_d = 1'b1;
            state_d     = ST_SERVE;
          end
        end

        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state_q     <= ST_SERVE;
      ball_x_q    <= POS_W'(BALL_X0);
      ball_y_q    <= POS_W'(BALL_Y0);
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      serve_dir_q <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      hit_q       <= 1'b0;
      point_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      serve_dir_q <= serve_dir_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hit_q       <= hit_d;
      point_q     <= point_d;
      hold_q      <= hold_d;
    end
  end

  pong_paddle_ctrl #(
    .POS_W (POS_W),
    .SPEED (PADDLE_SPEED),
    .Y_MAX (PADDLE_MAX),
    .Y_INIT(PADDLE_INI)
  ) u_player (
    .clk_div(clk_div),
    .rst_n  (rst_n),
    .en     (ply_en),
    .up     (btn_up),
    .down   (btn_down),
    .pos    (paddle_y)
  );

  pong_paddle_ctrl #(
    .POS_W (POS_W),
    .SPEED (AI_SPEED),
    .Y_MAX (PADDLE_MAX),
    .Y_INIT(PADDLE_INI)
  ) u_ai (
    .clk_div(clk_div),
    .rst_n  (rst_n),
    .en     (ai_en),
    .up     (ai_up),
    .down   (ai_down),
    .pos    (op_paddle_y)
  );

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign state     = state_q;
  assign hit       = hit_q;
  assign point     = point_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_physics.sv
module tb_pong_physics;

  logic       clk_div = 1'b0;
  logic       rst_n = 1'b0, tick_en = 1'b0, btn_up = 1'b0, btn_down = 1'b0, serve = 1'b0;
  logic [9:0] ball_x, ball_y, paddle_y, op_paddle_y;
  logic [3:0] score_l, score_r;
  logic [1:0] state;
  logic       hit, point, game_over;

  always #5 clk_div = ~clk_div;

  pong_physics dut (
    .clk_div(clk_div), .rst_n(rst_n), .tick_en(tick_en),
    .btn_up(btn_up), .btn_down(btn_down), .serve(serve),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y), .op_paddle_y(op_paddle_y),
    .score_l(score_l), .score_r(score_r), .state(state),
    .hit(hit), .point(point), .game_over(game_over)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural game model in plain integers, default geometry.
  int m_bx, m_by, m_py, m_oy, m_sl, m_sr, m_st, m_dx, m_dy, m_sd, m_hit, m_pt, m_ticks_in_point;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_bx = 315; m_by = 235; m_py = 210; m_oy = 210;
    m_sl = 0; m_sr = 0; m_st = 0; m_dx = 1; m_dy = 1; m_sd = 1;
    m_hit = 0; m_pt = 0; m_ticks_in_point = 0;
  endtask

  task automatic model_step(input bit r, input bit te, input bit up, input bit dn, input bit sv);
    int bx, by, py, oy, st, dx, dy;
    if (!r) begin
      model_reset();
      return;
    end
    if (!te) return;
    bx = m_bx; by = m_by; py = m_py; oy = m_oy; st = m_st; dx = m_dx; dy = m_dy;
    m_hit = 0; m_pt = 0;
    if (st == 0 || st == 1) begin
      if (up)      m_py = clampi(py - 2, 0, 420);
      else if (dn) m_py = clampi(py + 2, 0, 420);
    end
    if (st == 1) begin
      if (by + 5 < oy + 30)      m_oy = clampi(oy - 1, 0, 420);
      else if (by + 5 > oy + 30) m_oy = clampi(oy + 1, 0, 420);
    end
    case (st)
      0: begin
        m_bx = 315; m_by = 235;
        if (sv) begin m_dx = m_sd; m_dy = 1; m_st = 1; end
      end
      1: begin
        if (dy == 1 && by + 2 >= 470)      begin m_by = 470; m_dy = 0; end
        else if (dy == 0 && by <= 2)       begin m_by = 0;   m_dy = 1; end
        else                               m_by = by + (dy == 1 ? 2 : -2);
        if (dx == 1 && bx + 10 <= 610 && bx + 12 >= 610 && by + 10 > py && by < py + 60) begin
          m_bx = 600; m_dx = 0; m_hit = 1;
        end else if (dx == 0 && bx >= 30 && bx - 2 <= 30 && by + 10 > oy && by < oy + 60) begin
          m_bx = 30; m_dx = 1; m_hit = 1;
        end else if (dx == 1 && bx + 2 >= 630) begin
          m_sl = clampi(m_sl + 1, 0, 9); m_sd = 1; m_pt = 1; m_st = 2; m_ticks_in_point = 0;
        end else if (dx == 0 && bx <= 2) begin
          m_sr = clampi(m_sr + 1, 0, 9); m_sd = 0; m_pt = 1; m_st = 2; m_ticks_in_point = 0;
        end else begin
          m_bx = bx + (dx == 1 ? 2 : -2);
        end
      end
      2: begin
        m_bx = 315; m_by = 235;
        m_ticks_in_point++;
        if (m_ticks_in_point == 30) m_st = (m_sl == 9 || m_sr == 9) ? 3 : 0;
      end
      default: begin
        if (sv) begin m_sl = 0; m_sr = 0; m_sd = 1; m_st = 0; end
      end
    endcase
  endtask

  always @(negedge clk_div) begin
    if (chk_en) begin
      chk("ball_x", int'(ball_x), m_bx);
      chk("ball_y", int'(ball_y), m_by);
      chk("paddle_y", int'(paddle_y), m_py);
      chk("op_paddle_y", int'(op_paddle_y), m_oy);
      chk("score_l", int'(score_l), m_sl);
      chk("score_r", int'(score_r), m_sr);
      chk("state", int'(state), m_st);
      chk("hit", int'(hit), m_hit);
      chk("point", int'(point), m_pt);
      chk("game_over", int'(game_over), (m_st == 3) ? 1 : 0);
    end
  end

  task automatic cyc(input bit r, input bit te, input bit up, input bit dn, input bit sv);
    rst_n = r; tick_en = te; btn_up = up; btn_down = dn; serve = sv;
    @(posedge clk_div);
    model_step(r, te, up, dn, sv);
    #1;
  endtask

  int pcnt = 0, n_points = 0, n_hits = 0;

  // Drives one cycle and tracks POINT dwell and hit activity observed on the DUT.
  task automatic step_mon(input bit r, input bit te, input bit up, input bit dn, input bit sv);
    logic [1:0] s_before;
    s_before = state;
    cyc(r, te, up, dn, sv);
    if (!r) begin
      pcnt = 0;
    end else if (te) begin
      if (hit) n_hits++;
      if (s_before == 2'd2) begin
        pcnt++;
        if (state != 2'd2) begin
          chk("point_dwell", pcnt, 30);
          n_points++;
          pcnt = 0;
        end
      end
    end
  endtask

  initial begin
    bit te, r, sv, up, dn;
    bit got_over;
    model_reset();

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("rst_ball_x", int'(ball_x), 315);
    chk("rst_ball_y", int'(ball_y), 235);
    chk("rst_paddle_y", int'(paddle_y), 210);
    chk("rst_op_paddle_y", int'(op_paddle_y), 210);
    chk("rst_scores", int'(score_l) + int'(score_r), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_pulses", int'(hit) + int'(point), 0);

    step_mon(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("serve_state", int'(state), 1);
    chk("serve_ball_x", int'(ball_x), 315);
    chk("serve_ball_y", int'(ball_y), 235);
    step_mon(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("first_step_x", int'(ball_x), 317);
    chk("first_step_y", int'(ball_y), 237);
    chk("first_step_ai", int'(op_paddle_y), 210);

    for (int i = 0; i < 20000; i++) begin
      te = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 14999) != 0);
      sv = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        up = (m_by + 5 < m_py + 30);
        dn = (m_by + 5 > m_py + 30);
      end else begin
        up = $urandom_range(0, 1) != 0;
        dn = $urandom_range(0, 1) != 0;
      end
      step_mon(r, te, up, dn, sv);
    end

    // Park the player paddle at the top so points accumulate until a win.
    got_over = 1'b0;
    for (int i = 0; i < 30000 && !got_over; i++) begin
      step_mon(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      if (game_over) got_over = 1'b1;
    end
    chk("game_over_reached", int'(got_over), 1);
    chk("win_score", (score_l == 4'd9 || score_r == 4'd9) ? 1 : 0, 1);
    chk("over_state", int'(state), 3);
    step_mon(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_scores", int'(score_l) + int'(score_r), 0);
    chk("restart_state", int'(state), 0);
    chk("restart_game_over", int'(game_over), 0);

    chk("hits_seen", (n_hits > 0) ? 1 : 0, 1);
    chk("points_seen", (n_points > 0) ? 1 : 0, 1);

    chk_en = 1'b0;
    @(posedge clk_div);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
